// File: rtl/riscv_ex_issue.sv
// riscv_ex_issue: one-entry issue register between decode and the execute ALU.
// Build macro RISCV_EX_FWD_EN enables MEM/WB operand bypass; without it, RAW hazards interlock.
module riscv_ex_issue #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic [4:0]      i_id_rd_addr,
  input  logic            i_id_rd_we,
  input  logic [3:0]      i_id_alu_ctrl,
  input  logic            i_id_a_sel,
  input  logic            i_id_b_sel,
  input  logic            i_mem_rd_we,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic [XLEN-1:0] i_mem_rd_data,
  input  logic            i_wb_rd_we,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic [XLEN-1:0] i_wb_rd_data,
  input  logic            i_flush,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [4:0]      o_ex_rd_addr,
  output logic            o_ex_rd_we
);

`ifdef RISCV_EX_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [3:0]      ctrl;
    logic            a_sel;
    logic            b_sel;
  } entry_t;

  logic            full_q, full_d;
  entry_t          ent_q, ent_d;
  logic            last_we_q, last_we_d;
  logic [4:0]      last_rd_q, last_rd_d;
  logic            hazard, ex_valid, id_ready, issue, capture;
  logic [XLEN-1:0] rs1_op, rs2_op;

  // x0 is hardwired; the younger MEM result wins over WB.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0]      addr,
                                          input logic [XLEN-1:0] v,
                                          input logic            use_mem);
    if (addr == 5'd0) return '0;
    if (use_mem && i_mem_rd_we && (i_mem_rd_addr == addr)) return i_mem_rd_data;
    if (i_wb_rd_we && (i_wb_rd_addr == addr)) return i_wb_rd_data;
    return v;
  endfunction

  // A source is not yet usable while its producer is in MEM, was issued last
  // cycle, or is landing through WB (the refresh picks it up at this edge).
  function automatic logic src_busy(input logic [4:0] addr);
    return (addr != 5'd0) &&
           ((i_mem_rd_we && (i_mem_rd_addr == addr)) ||
            (last_we_q   && (last_rd_q     == addr)) ||
            (i_wb_rd_we  && (i_wb_rd_addr  == addr)));
  endfunction

  assign hazard   = !FwdEn && full_q &&
                    ((!ent_q.a_sel && src_busy(ent_q.rs1_addr)) || src_busy(ent_q.rs2_addr));
  assign ex_valid = full_q && !hazard && !i_flush;
  assign issue    = ex_valid && i_ex_ready;
  assign id_ready = !full_q || issue;
  assign capture  = i_id_valid && id_ready && !i_flush;

  assign rs1_op = FwdEn ? fwd(ent_q.rs1_addr, ent_q.rs1v, 1'b1) : ent_q.rs1v;
  assign rs2_op = FwdEn ? fwd(ent_q.rs2_addr, ent_q.rs2v, 1'b1) : ent_q.rs2v;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    full_d    = full_q;
    ent_d     = ent_q;
    last_we_d = last_we_q;
    last_rd_d = last_rd_q;
    if (i_flush) begin
      full_d    = 1'b0;
      last_we_d = 1'b0;
      last_rd_d = 5'd0;
    end else begin
      last_we_d = issue && ent_q.rd_we;
      if (issue) last_rd_d = ent_q.rd_addr;
      if (capture) begin
        full_d         = 1'b1;
        ent_d.pc       = i_id_pc;
        ent_d.rs1v     = fwd(i_id_rs1_addr, i_id_rs1_data, FwdEn);
        ent_d.rs2v     = fwd(i_id_rs2_addr, i_id_rs2_data, FwdEn);
        ent_d.imm      = i_id_imm;
        ent_d.rs1_addr = i_id_rs1_addr;
        ent_d.rs2_addr = i_id_rs2_addr;
        ent_d.rd_addr  = i_id_rd_addr;
        ent_d.rd_we    = i_id_rd_we;
        ent_d.ctrl     = i_id_alu_ctrl;
        ent_d.a_sel    = i_id_a_sel;
        ent_d.b_sel    = i_id_b_sel;
      end else begin
        if (issue) full_d = 1'b0;
        // Refresh keeps a bypassed value after it has left the buses.
        if (full_q) begin
          ent_d.rs1v = fwd(ent_q.rs1_addr, ent_q.rs1v, FwdEn);
          ent_d.rs2v = fwd(ent_q.rs2_addr, ent_q.rs2v, FwdEn);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      full_q    <= 1'b0;
      ent_q     <= '0;
      last_we_q <= 1'b0;
      last_rd_q <= 5'd0;
    end else begin
      full_q    <= full_d;
      ent_q     <= ent_d;
      last_we_q <= last_we_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign o_id_ready    = id_ready;
  assign o_ex_valid    = ex_valid;
  assign o_alu_a       = ent_q.a_sel ? ent_q.pc  : rs1_op;
  assign o_alu_b       = ent_q.b_sel ? ent_q.imm : rs2_op;
  assign o_alu_ctrl    = ent_q.ctrl;
  assign o_ex_pc       = ent_q.pc;
  assign o_ex_rs2_data = rs2_op;
  assign o_ex_rd_addr  = ent_q.rd_addr;
  assign o_ex_rd_we    = ent_q.rd_we;

endmodule

// File: tb/tb_riscv_ex_issue.sv
// tb_riscv_ex_issue: directed scenarios plus random traffic against an instruction-level model.
// Honours RISCV_EX_FWD_EN the same way the design does.
module tb_riscv_ex_issue;
  localparam int XLEN = 32;
`ifdef RISCV_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_id_valid, o_id_ready;
  logic [XLEN-1:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [4:0]      i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic            i_id_rd_we;
  logic [3:0]      i_id_alu_ctrl;
  logic            i_id_a_sel, i_id_b_sel;
  logic            i_mem_rd_we;
  logic [4:0]      i_mem_rd_addr;
  logic [XLEN-1:0] i_mem_rd_data;
  logic            i_wb_rd_we;
  logic [4:0]      i_wb_rd_addr;
  logic [XLEN-1:0] i_wb_rd_data;
  logic            i_flush;
  logic            o_ex_valid, i_ex_ready;
  logic [XLEN-1:0] o_alu_a, o_alu_b, o_ex_pc, o_ex_rs2_data;
  logic [3:0]      o_alu_ctrl;
  logic [4:0]      o_ex_rd_addr;
  logic            o_ex_rd_we;

  riscv_ex_issue #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc), .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_imm(i_id_imm), .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_rd_we(i_id_rd_we), .i_id_alu_ctrl(i_id_alu_ctrl),
    .i_id_a_sel(i_id_a_sel), .i_id_b_sel(i_id_b_sel),
    .i_mem_rd_we(i_mem_rd_we), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_data(i_mem_rd_data),
    .i_wb_rd_we(i_wb_rd_we), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_data(i_wb_rd_data),
    .i_flush(i_flush), .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
    .o_ex_pc(o_ex_pc), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_we(o_ex_rd_we)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the held instruction, and what was issued one cycle ago.
  typedef struct {
    bit          full;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    bit          we;
    logic [3:0]  ctrl;
    bit          asel, bsel;
  } ent_t;

  ent_t       m;
  bit         m_lwe;
  logic [4:0] m_lrd;
  bit         e_valid, e_ready;

  function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] v, input bit use_mem);
    if (a == 5'd0) return 32'd0;
    if (use_mem && i_mem_rd_we && i_mem_rd_addr == a) return i_mem_rd_data;
    if (i_wb_rd_we && i_wb_rd_addr == a) return i_wb_rd_data;
    return v;
  endfunction

  function automatic bit pending(input logic [4:0] a);
    return (a != 5'd0) && ((i_mem_rd_we && i_mem_rd_addr == a) ||
                           (m_lwe && m_lrd == a) ||
                           (i_wb_rd_we && i_wb_rd_addr == a));
  endfunction

  task automatic model_reset();
    m     = '{default: '0};
    m_lwe = 1'b0;
    m_lrd = 5'd0;
  endtask

  // Let combinational outputs settle for the current inputs and compare every output.
  task automatic settle();
    logic [31:0] s1, s2;
    bit          stall;
    #2;
    stall   = !FWD && ((!m.asel && pending(m.a1)) || pending(m.a2));
    e_valid = m.full && !i_flush && !stall;
    e_ready = !m.full || (e_valid && i_ex_ready);
    s1 = FWD ? bypass(m.a1, m.r1, 1'b1) : m.r1;
    s2 = FWD ? bypass(m.a2, m.r2, 1'b1) : m.r2;
    check("ex_valid", 32'(o_ex_valid), 32'(e_valid));
    check("id_ready", 32'(o_id_ready), 32'(e_ready));
    check("alu_a", o_alu_a, m.asel ? m.pc : s1);
    check("alu_b", o_alu_b, m.bsel ? m.imm : s2);
    check("alu_ctrl", 32'(o_alu_ctrl), 32'(m.ctrl));
    check("ex_pc", o_ex_pc, m.pc);
    check("rs2_data", o_ex_rs2_data, s2);
    check("rd_addr", 32'(o_ex_rd_addr), 32'(m.rd));
    check("rd_we", 32'(o_ex_rd_we), 32'(m.we));
  endtask

  // Apply this cycle's transfer rules to the model, then move to the next cycle.
  task automatic advance();
    bit iss, cap;
    iss = e_valid && i_ex_ready;
    cap = i_id_valid && e_ready && !i_flush;
    if (i_flush) begin
      m.full = 1'b0;
      m_lwe  = 1'b0;
      m_lrd  = 5'd0;
    end else begin
      m_lwe = iss && m.we;
      if (iss) m_lrd = m.rd;
      if (cap) begin
        m.full = 1'b1;
        m.pc   = i_id_pc;
        m.r1   = bypass(i_id_rs1_addr, i_id_rs1_data, FWD);
        m.r2   = bypass(i_id_rs2_addr, i_id_rs2_data, FWD);
        m.imm  = i_id_imm;
        m.a1   = i_id_rs1_addr;
        m.a2   = i_id_rs2_addr;
        m.rd   = i_id_rd_addr;
        m.we   = i_id_rd_we;
        m.ctrl = i_id_alu_ctrl;
        m.asel = i_id_a_sel;
        m.bsel = i_id_b_sel;
      end else begin
        if (m.full) begin
          m.r1 = bypass(m.a1, m.r1, FWD);
          m.r2 = bypass(m.a2, m.r2, FWD);
        end
        if (iss) m.full = 1'b0;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic we, input logic [3:0] ctrl,
                       input logic asel, input logic bsel);
    i_id_valid    = 1'b1;
    i_id_pc       = pc;
    i_id_rs1_addr = r1;  i_id_rs1_data = d1;
    i_id_rs2_addr = r2;  i_id_rs2_data = d2;
    i_id_imm      = imm;
    i_id_rd_addr  = rd;  i_id_rd_we    = we;
    i_id_alu_ctrl = ctrl;
    i_id_a_sel    = asel; i_id_b_sel   = bsel;
  endtask

  task automatic buses_idle();
    i_mem_rd_we = 1'b0; i_mem_rd_addr = 5'd0; i_mem_rd_data = '0;
    i_wb_rd_we  = 1'b0; i_wb_rd_addr  = 5'd0; i_wb_rd_data  = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_ex_ready = 1'b0;
    offer(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    i_id_valid = 1'b0;
    buses_idle();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2;
    check("rst_valid", 32'(o_ex_valid), 32'd0);
    check("rst_ready", 32'(o_id_ready), 32'd1);
    check("rst_alu_a", o_alu_a, 32'd0);
    check("rst_alu_b", o_alu_b, 32'd0);
    i_rst = 1'b0;
    model_reset();
    @(negedge i_clk);

    // Immediate add: x5 (10) + 7.
    offer(32'h100, 5'd5, 32'd10, 5'd0, 32'd0, 32'd7, 5'd1, 1'b1, 4'd0, 1'b0, 1'b1);
    step();
    i_id_valid = 1'b0;
    settle();
    check("add_valid", 32'(o_ex_valid), 32'd1);
    check("add_a", o_alu_a, 32'd10);
    check("add_b", o_alu_b, 32'd7);
    advance();

    // Back-pressure for three cycles with a younger instruction waiting.
    offer(32'h200, 5'd6, 32'd20, 5'd7, 32'd3, 32'd0, 5'd2, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_ready", 32'(o_id_ready), 32'd0);
      check("bp_a", o_alu_a, 32'd10);
      advance();
    end
    i_ex_ready = 1'b1;
    settle();
    check("bp_release", 32'(o_id_ready), 32'd1);
    advance();
    i_id_valid = 1'b0; i_ex_ready = 1'b0;
    settle();
    check("bp_next_a", o_alu_a, 32'd20);
    check("bp_next_pc", o_ex_pc, 32'h200);
    advance();

    // Bypass priority on a held rs1 = x3.
    i_ex_ready = 1'b1;
    step();
    i_ex_ready = 1'b0;
    offer(32'h240, 5'd3, 32'h11, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step();
    i_id_valid = 1'b0;
    i_mem_rd_we = 1'b1; i_mem_rd_addr = 5'd3; i_mem_rd_data = 32'h55;
    i_wb_rd_we  = 1'b1; i_wb_rd_addr  = 5'd3; i_wb_rd_data  = 32'h22;
    settle();
`ifdef RISCV_EX_FWD_EN
    check("byp_mem_wins", o_alu_a, 32'h55);
`else
    check("byp_stall", 32'(o_ex_valid), 32'd0);
`endif
    advance();
    buses_idle();
    settle();
`ifdef RISCV_EX_FWD_EN
    check("byp_retained", o_alu_a, 32'h55);
`else
    check("wb_refreshed", o_alu_a, 32'h22);
`endif
    advance();

    // Flush with a new offer: both the held and the offered entry die.
    offer(32'h280, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd3, 1'b1, 4'd2, 1'b0, 1'b0);
    i_flush = 1'b1; i_ex_ready = 1'b1;
    settle();
    check("flush_now", 32'(o_ex_valid), 32'd0);
    advance();
    i_flush = 1'b0; i_id_valid = 1'b0;
    settle();
    check("flush_after", 32'(o_ex_valid), 32'd0);
    advance();

    // x0 guard.
    i_ex_ready = 1'b0;
    offer(32'h2c0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    i_id_valid = 1'b0;
    i_mem_rd_we = 1'b1; i_mem_rd_addr = 5'd0; i_mem_rd_data = 32'hFF;
    settle();
    check("x0_a", o_alu_a, 32'd0);
    check("x0_valid", 32'(o_ex_valid), 32'd1);
    advance();
    buses_idle();
    i_ex_ready = 1'b1;
    step();

    // Back-to-back dependency: add x4, then sub reading x4.
    offer(32'h300, 5'd1, 32'd5, 5'd2, 32'd4, 32'd0, 5'd4, 1'b1, 4'd0, 1'b0, 1'b0);
    step();
    offer(32'h304, 5'd4, 32'd0, 5'd0, 32'd0, 32'd1, 5'd5, 1'b1, 4'd8, 1'b0, 1'b1);
    step();
    i_id_valid = 1'b0;
    i_mem_rd_we = 1'b1; i_mem_rd_addr = 5'd4; i_mem_rd_data = 32'd9;
    settle();
`ifdef RISCV_EX_FWD_EN
    check("b2b_valid", 32'(o_ex_valid), 32'd1);
    check("b2b_a", o_alu_a, 32'd9);
`else
    check("lock_mem", 32'(o_ex_valid), 32'd0);
`endif
    advance();
    buses_idle();
    i_wb_rd_we = 1'b1; i_wb_rd_addr = 5'd4; i_wb_rd_data = 32'd9;
    settle();
`ifndef RISCV_EX_FWD_EN
    check("lock_wb", 32'(o_ex_valid), 32'd0);
`endif
    advance();
    buses_idle();
    settle();
`ifndef RISCV_EX_FWD_EN
    check("lock_rise", 32'(o_ex_valid), 32'd1);
    check("lock_a", o_alu_a, 32'd9);
`endif
    advance();

    // Random traffic over a small register window so bypass and hazards collide often.
    for (int k = 0; k < 3000; k++) begin
      offer($urandom, 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
            $urandom, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      i_id_valid    = ($urandom_range(0, 3) != 0);
      i_mem_rd_we   = ($urandom_range(0, 2) == 0);
      i_mem_rd_addr = 5'($urandom_range(0, 3));
      i_mem_rd_data = $urandom;
      i_wb_rd_we    = ($urandom_range(0, 2) == 0);
      i_wb_rd_addr  = 5'($urandom_range(0, 3));
      i_wb_rd_data  = $urandom;
      i_flush       = ($urandom_range(0, 19) == 0);
      i_ex_ready    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
